// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared constants, time type and FSM encoding for the
//                multi-slot alarm scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    localparam int MIN_MAX   = 59;
    localparam int HOUR_MAX  = 23;
    localparam int SENT_MIN  = 63;
    localparam int SENT_HOUR = 31;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
    } alarm_time_t;

    // Sentinel time that can never match a legal counter value
    localparam alarm_time_t SENT_TIME = {5'(SENT_HOUR), 6'(SENT_MIN)};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RING = 1'b1
    } alarm_state_e;

endpackage : alarm_pkg
`default_nettype wire

// File: rtl/alarm_time_add.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_time_add
//  Description : Combinational hh:mm + ADD_MIN minutes, wrapping 23:59 -> 00:00.
//                Inputs are assumed to be a legal time of day.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_time_add
    import alarm_pkg::*;
#(
    parameter int ADD_MIN = 10
) (
    input  alarm_time_t t_i,
    output alarm_time_t t_o
);

    logic [6:0] w_min_sum;
    logic       w_carry;

    // Minute addition with at most one hour of carry, hour wraps at midnight
    always_comb begin
        w_min_sum = {1'b0, t_i.min} + 7'(ADD_MIN);
        w_carry   = (w_min_sum > 7'(MIN_MAX));
        t_o.min   = w_carry ? 6'(w_min_sum - 7'd60) : w_min_sum[5:0];
        if (!w_carry) begin
            t_o.hour = t_i.hour;
        end else if (t_i.hour >= 5'(HOUR_MAX)) begin
            t_o.hour = '0;
        end else begin
            t_o.hour = t_i.hour + 5'd1;
        end
    end

endmodule : alarm_time_add
`default_nettype wire

// File: rtl/alarm_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_scheduler
//  Description : NUM_ALARMS daily alarm slots compared against the hh:mm
//                counter on every minute change. Lowest pending slot wins the
//                single ringer; handles stop, ring timeout and (optionally)
//                snooze. Snooze support is built only when the macro
//                ALARM_SNOOZE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_scheduler
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS   = 4,
    parameter int SNOOZE_MIN   = 10,
    parameter int RING_MINUTES = 5,
    localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [5:0]    minute_counter,
    input  logic [4:0]    ore_counter,
    input  logic          load,
    input  logic [SW-1:0] slot_sel,
    input  logic          arm,
    input  logic [5:0]    minute_setare,
    input  logic [4:0]    ore_setare,
    input  logic          stop,
    input  logic          snooze,
    output logic          semnal,
    output logic [SW-1:0] active_slot,
    output logic          pending_any
);

    // ------------------------------------------------------------------------
    // Minute tick detection
    // ------------------------------------------------------------------------
    alarm_time_t w_now;
    alarm_time_t prev_q;
    logic        w_tick;

    assign w_now  = {ore_counter, minute_counter};
    assign w_tick = (w_now != prev_q);

    // Previous counter sample; sentinel reset makes the first sample a tick
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= SENT_TIME;
        end else begin
            prev_q <= w_now;
        end
    end

    // ------------------------------------------------------------------------
    // Load decode
    // ------------------------------------------------------------------------
    logic                  w_load_valid;
    alarm_time_t           w_load_time;
    logic [NUM_ALARMS-1:0] w_load_vec;

    assign w_load_valid = arm && (ore_setare <= 5'(HOUR_MAX))
                              && (minute_setare <= 6'(MIN_MAX));
    assign w_load_time  = {ore_setare, minute_setare};

    // One-hot slot write strobe
    always_comb begin
        w_load_vec = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (load && (slot_sel == SW'(i))) begin
                w_load_vec[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Ring control signals
    // ------------------------------------------------------------------------
    alarm_state_e          state_q;
    alarm_state_e          state_d;
    logic [SW-1:0]         active_q;
    logic [3:0]            ring_cnt_q;
    logic                  pending_any_q;
    logic [NUM_ALARMS-1:0] armed_q;
    logic [NUM_ALARMS-1:0] armed_d;
    logic [NUM_ALARMS-1:0] pending_q;
    logic [NUM_ALARMS-1:0] pending_d;
    alarm_time_t           alm_q [NUM_ALARMS];
    alarm_time_t           alm_d [NUM_ALARMS];

    logic                  w_ringing;
    logic                  w_timeout;
    logic                  w_dismiss;
    logic                  w_snooze_take;
    logic                  w_active_loaded;
    logic [NUM_ALARMS-1:0] w_act_vec;
    logic [NUM_ALARMS-1:0] w_end_vec;
    logic [NUM_ALARMS-1:0] w_pend_eff;
    logic [NUM_ALARMS-1:0] w_alarm_hit;
    logic [NUM_ALARMS-1:0] w_snz_hit;
    logic [SW-1:0]         w_first;
    alarm_time_t           w_snz_sum;

    assign w_ringing       = (state_q == RING);
    assign w_timeout       = w_ringing && w_tick
                             && (ring_cnt_q == 4'(RING_MINUTES - 1));
    // stop and timeout share the same dismiss path; either beats snooze
    assign w_dismiss       = w_ringing && (stop || w_timeout);
    assign w_active_loaded = w_ringing && (|(w_load_vec & w_act_vec));
    assign w_end_vec       = w_act_vec & {NUM_ALARMS{w_dismiss || w_snooze_take}};
    // A slot being reloaded this cycle is not eligible to start ringing
    assign w_pend_eff      = pending_q & ~w_load_vec;

    // Active slot one-hot, alarm matches and lowest-index pending slot
    always_comb begin
        w_act_vec   = '0;
        w_alarm_hit = '0;
        w_first     = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            w_act_vec[i]   = (active_q == SW'(i));
            w_alarm_hit[i] = armed_q[i] && (alm_q[i] == w_now);
        end
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (w_pend_eff[i]) begin
                w_first = SW'(i);
            end
        end
    end

    alarm_time_add #(
        .ADD_MIN (SNOOZE_MIN)
    ) u_snz_add (
        .t_i (w_now),
        .t_o (w_snz_sum)
    );

    // ------------------------------------------------------------------------
    // Snooze bookkeeping
    // ------------------------------------------------------------------------
`ifdef ALARM_SNOOZE_EN
    logic [NUM_ALARMS-1:0] snz_active_q;
    logic [NUM_ALARMS-1:0] snz_active_d;
    alarm_time_t           snz_time_q [NUM_ALARMS];
    alarm_time_t           snz_time_d [NUM_ALARMS];

    assign w_snooze_take = w_ringing && snooze && !w_dismiss;

    // Snooze hit detection and per-slot snooze next state
    always_comb begin
        w_snz_hit    = '0;
        snz_active_d = snz_active_q;
        snz_time_d   = snz_time_q;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            w_snz_hit[i] = snz_active_q[i] && (snz_time_q[i] == w_now);
            if (w_load_vec[i]) begin
                snz_active_d[i] = 1'b0;
            end else if (w_snooze_take && w_act_vec[i]) begin
                snz_active_d[i] = 1'b1;
                snz_time_d[i]   = w_snz_sum;
            end else if (w_tick && w_snz_hit[i]) begin
                snz_active_d[i] = 1'b0;
            end
        end
    end

    // Snooze state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            snz_active_q <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                snz_time_q[i] <= SENT_TIME;
            end
        end else begin
            snz_active_q <= snz_active_d;
            snz_time_q   <= snz_time_d;
        end
    end
`else
    logic [11:0] w_unused_snz;

    assign w_snooze_take = 1'b0;
    assign w_snz_hit     = '0;
    assign w_unused_snz  = {snooze, w_snz_sum};
`endif

    // ------------------------------------------------------------------------
    // Slot state: load has priority, then ring end, then a new match
    // ------------------------------------------------------------------------
    // Per-slot next state
    always_comb begin
        armed_d   = armed_q;
        alm_d     = alm_q;
        pending_d = pending_q;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (w_load_vec[i]) begin
                armed_d[i]   = w_load_valid;
                alm_d[i]     = w_load_valid ? w_load_time : SENT_TIME;
                pending_d[i] = 1'b0;
            end else if (w_end_vec[i]) begin
                pending_d[i] = 1'b0;
            end else if (w_tick && (w_alarm_hit[i] || w_snz_hit[i])) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    // Per-slot registers
    always_ff @(posedge clock) begin
        if (reset) begin
            armed_q   <= '0;
            pending_q <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alm_q[i] <= SENT_TIME;
            end
        end else begin
            armed_q   <= armed_d;
            pending_q <= pending_d;
            alm_q     <= alm_d;
        end
    end

    // ------------------------------------------------------------------------
    // Ring FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|w_pend_eff) begin
                    state_d = RING;
                end
            end
            RING: begin
                if (w_dismiss || w_snooze_take || w_active_loaded) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Active slot latch on RING entry and per-tick ring duration counter
    always_ff @(posedge clock) begin
        if (reset) begin
            active_q   <= '0;
            ring_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (|w_pend_eff) begin
                active_q   <= w_first;
                ring_cnt_q <= '0;
            end
        end else if (w_tick) begin
            ring_cnt_q <= ring_cnt_q + 4'd1;
        end
    end

    // Registered summary of pending slots
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_any_q <= 1'b0;
        end else begin
            pending_any_q <= |pending_q;
        end
    end

    // Output decode
    always_comb begin
        semnal      = (state_q == RING);
        active_slot = (state_q == RING) ? active_q : '0;
        pending_any = pending_any_q;
    end

endmodule : alarm_scheduler
`default_nettype wire

// File: tb/tb_alarm_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_scheduler
//  Description : Self-checking bench for alarm_scheduler: directed scenarios
//                followed by random traffic against a minute-of-day model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_scheduler;

    localparam int N   = 4;
    localparam int SNZ = 10;
    localparam int RM  = 5;
    localparam int SW  = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [5:0]    minute_counter;
    logic [4:0]    ore_counter;
    logic          load;
    logic [SW-1:0] slot_sel;
    logic          arm;
    logic [5:0]    minute_setare;
    logic [4:0]    ore_setare;
    logic          stop;
    logic          snooze;
    logic          semnal;
    logic [SW-1:0] active_slot;
    logic          pending_any;

    always #5 clock = ~clock;

    alarm_scheduler #(
        .NUM_ALARMS   (N),
        .SNOOZE_MIN   (SNZ),
        .RING_MINUTES (RM)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .minute_counter (minute_counter),
        .ore_counter    (ore_counter),
        .load           (load),
        .slot_sel       (slot_sel),
        .arm            (arm),
        .minute_setare  (minute_setare),
        .ore_setare     (ore_setare),
        .stop           (stop),
        .snooze         (snooze),
        .semnal         (semnal),
        .active_slot    (active_slot),
        .pending_any    (pending_any)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: times kept as minute-of-day integers
    bit m_armed [N];
    int m_at    [N];
    bit m_pend  [N];
    bit m_snz   [N];
    int m_st    [N];
    bit m_ring;
    int m_act;
    int m_cnt;
    int m_prev;
    bit m_pany;
    int now_md;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_armed[i] = 0; m_at[i] = -1; m_pend[i] = 0; m_snz[i] = 0; m_st[i] = -1;
        end
        m_ring = 0; m_act = 0; m_cnt = 0; m_prev = -1; m_pany = 0;
    endtask

    task automatic model_edge();
        int  now;
        bit  tick;
        bit  pend_old [N];
        bit  pany_next;
        bit  tout;
        now  = int'(ore_counter) * 60 + int'(minute_counter);
        tick = (now != m_prev);
        pany_next = 0;
        for (int i = 0; i < N; i++) begin
            pend_old[i] = m_pend[i];
            pany_next   = pany_next | m_pend[i];
        end
        // new matches on a minute change
        if (tick) begin
            for (int i = 0; i < N; i++) begin
                if (m_armed[i] && m_at[i] == now) m_pend[i] = 1;
                if (m_snz[i] && m_st[i] == now) begin
                    m_pend[i] = 1;
                    m_snz[i]  = 0;
                end
            end
        end
        // ringer arbitration
        if (m_ring) begin
            tout = tick && (m_cnt + 1 >= RM);
            if (stop || tout) begin
                m_pend[m_act] = 0;
                m_ring = 0;
            end
`ifdef ALARM_SNOOZE_EN
            else if (snooze) begin
                m_pend[m_act] = 0;
                m_snz[m_act]  = 1;
                m_st[m_act]   = (now + SNZ) % 1440;
                m_ring = 0;
            end
`endif
            else if (load && int'(slot_sel) == m_act) begin
                m_ring = 0;
            end else if (tick) begin
                m_cnt++;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!m_ring && pend_old[i] && !(load && int'(slot_sel) == i)) begin
                    m_ring = 1;
                    m_act  = i;
                    m_cnt  = 0;
                end
            end
        end
        // slot write overrides everything for that slot
        if (load) begin
            m_armed[slot_sel] = arm && (ore_setare <= 23) && (minute_setare <= 59);
            m_at[slot_sel]    = int'(ore_setare) * 60 + int'(minute_setare);
            m_snz[slot_sel]   = 0;
            m_pend[slot_sel]  = 0;
        end
        m_prev = now;
        m_pany = pany_next;
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_reset();
        else       model_edge();
        #1;
        chk("semnal",      32'(semnal),      32'(m_ring));
        chk("active_slot", 32'(active_slot), m_ring ? 32'(m_act) : 32'd0);
        chk("pending_any", 32'(pending_any), 32'(m_pany));
    endtask

    task automatic set_time(input int md);
        now_md         = md;
        ore_counter    = 5'(md / 60);
        minute_counter = 6'(md % 60);
    endtask

    task automatic load_slot(input int s, input bit a, input int h, input int m);
        load          = 1'b1;
        slot_sel      = SW'(s);
        arm           = a;
        ore_setare    = 5'(h);
        minute_setare = 6'(m);
        step();
        load = 1'b0;
    endtask

    // Ring a loaded alarm at minute-of-day t: tick into t, then one more edge
    task automatic ring_at(input int t);
        set_time((t + 1439) % 1440); step();
        set_time(t); step();
        step();
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; slot_sel = '0; arm = 1'b0;
        ore_setare = '0; minute_setare = '0; stop = 1'b0; snooze = 1'b0;
        set_time(0);
        model_reset();
        step(); step();
        chk("rst_semnal", 32'(semnal), 32'd0);
        chk("rst_active", 32'(active_slot), 32'd0);
        chk("rst_pany",   32'(pending_any), 32'd0);
        reset = 1'b0;

        // slot1 07:30 rings two edges after the time change
        set_time(7*60 + 29); step();
        load_slot(1, 1, 7, 30);
        set_time(7*60 + 30); step();
        chk("t1_not_yet", 32'(semnal), 32'd0);
        step();
        chk("t1_ring",   32'(semnal), 32'd1);
        chk("t1_slot",   32'(active_slot), 32'd1);
        chk("t1_pany",   32'(pending_any), 32'd1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("t1_stop",   32'(semnal), 32'd0);
        step();
        ring_at(7*60 + 30);
        chk("t1_rearm",  32'(semnal), 32'd1);
        stop = 1'b1; step(); stop = 1'b0; step();

        // two slots at 12:00: lowest index first
        load_slot(0, 1, 12, 0);
        load_slot(2, 1, 12, 0);
        ring_at(12*60);
        chk("t2_first",  32'(active_slot), 32'd0);
        stop = 1'b1; step(); stop = 1'b0;
        chk("t2_gap",    32'(semnal), 32'd0);
        step();
        chk("t2_second", 32'(semnal), 32'd1);
        chk("t2_slot2",  32'(active_slot), 32'd2);
        stop = 1'b1; step(); stop = 1'b0; step();

        // timeout after RM ticks
        load_slot(3, 1, 6, 0);
        ring_at(6*60);
        chk("t3_ring",   32'(active_slot), 32'd3);
        for (int k = 1; k < RM; k++) begin
            set_time(6*60 + k); step();
            chk("t3_hold", 32'(semnal), 32'd1);
        end
        set_time(6*60 + RM); step();
        chk("t3_timeout", 32'(semnal), 32'd0);
        step();
        chk("t3_pany",   32'(pending_any), 32'd0);

        // snooze across midnight
        load_slot(0, 1, 23, 55);
        ring_at(23*60 + 55);
        chk("t4_ring",   32'(semnal), 32'd1);
        snooze = 1'b1; step(); snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        chk("t4_snoozed", 32'(semnal), 32'd0);
`else
        chk("t4_ignored", 32'(semnal), 32'd1);
`endif
        stop = 1'b1; step(); stop = 1'b0; step();
        for (int t = 23*60 + 56; t <= 24*60 + 5; t++) begin
            set_time(t % 1440); step();
        end
        step();
`ifdef ALARM_SNOOZE_EN
        chk("t4_resnooze", 32'(semnal), 32'd1);
        stop = 1'b1; step(); stop = 1'b0; step();
`else
        chk("t4_no_again", 32'(semnal), 32'd0);
`endif

        // illegal hour disarms the slot
        load_slot(3, 1, 24, 0);
        ring_at(6*60);
        chk("t5_disarmed", 32'(semnal), 32'd0);
        chk("t5_pany",     32'(pending_any), 32'd0);

        // reloading the ringing slot silences it
        ring_at(7*60 + 30);
        chk("t6_ring",    32'(semnal), 32'd1);
        load_slot(1, 1, 8, 0);
        chk("t6_load",    32'(semnal), 32'd0);

        // reset mid-ring clears everything
        ring_at(8*60);
        chk("t7_ring",    32'(semnal), 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t7_rst_sem", 32'(semnal), 32'd0);
        chk("t7_rst_act", 32'(active_slot), 32'd0);
        chk("t7_rst_pa",  32'(pending_any), 32'd0);
        ring_at(8*60);
        chk("t7_forgot",  32'(semnal), 32'd0);

        // random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            int r;
            int tgt;
            r = $urandom_range(0, 99);
            if (r >= 50 && r < 92)      set_time((now_md + 1) % 1440);
            else if (r >= 92)           set_time($urandom_range(0, 1439));
            if ($urandom_range(0, 99) < 8) begin
                load          = 1'b1;
                slot_sel      = SW'($urandom_range(0, N - 1));
                arm           = ($urandom_range(0, 9) < 8);
                tgt           = (now_md + $urandom_range(1, 4)) % 1440;
                ore_setare    = 5'(tgt / 60);
                minute_setare = 6'(tgt % 60);
                if ($urandom_range(0, 9) == 0) ore_setare    = 5'($urandom_range(24, 31));
                if ($urandom_range(0, 9) == 0) minute_setare = 6'($urandom_range(60, 63));
            end
            stop   = m_ring && ($urandom_range(0, 99) < 12);
            snooze = m_ring && ($urandom_range(0, 99) < 12);
            step();
            load = 1'b0; stop = 1'b0; snooze = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alarm_scheduler
`default_nettype wire
